// File: rtl/fpmult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_rr_arbiter
// Purpose  : Round-robin sharing of one single-occupancy multiplier among NREQ requesters.
// Revision : 1.0
// ============================================================================
module fpmult_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int n    = 32,
  localparam int OW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*2*n-1:0]   req_msg,
  output logic [NREQ-1:0]       resp_val,
  input  logic [NREQ-1:0]       resp_rdy,
  output logic [n-1:0]          resp_msg,
  output logic                  mult_recv_val,
  input  logic                  mult_recv_rdy,
  output logic [2*n-1:0]        mult_recv_msg,
  input  logic                  mult_send_val,
  output logic                  mult_send_rdy,
  input  logic [n-1:0]          mult_send_msg,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  output logic [15:0]           ops_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [OW:0] c_nreq = (OW+1)'(NREQ);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   r_owner;
  logic [2*n-1:0]  r_op;
  logic [n-1:0]    r_res;
  logic [15:0]     r_ops;

  logic [OW-1:0]   w_grant;
  logic            w_any;
  logic [2*n-1:0]  w_sel_msg;
  logic [NREQ-1:0] w_grant_oh;

  // First requesting index at or after r_ptr, wrapping modulo NREQ.
  always_comb begin : p_grant
    logic [OW:0] w_sum;
    w_grant = '0;
    w_any   = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (OW+1)'(k);
      if (w_sum >= c_nreq) begin
        w_sum = w_sum - c_nreq;
      end
      if (!w_any && req_val[w_sum[OW-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_sum[OW-1:0];
      end
    end
  end

  always_comb begin : p_sel
    w_sel_msg  = '0;
    w_grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == OW'(i)) begin
        w_sel_msg     = req_msg[i*2*n +: 2*n];
        w_grant_oh[i] = 1'b1;
      end
    end
  end

  // req_rdy is gated by reset so it falls immediately even though IDLE is combinational.
  always_comb begin : p_fsm
    w_state_nxt   = r_state;
    req_rdy       = '0;
    resp_val      = '0;
    mult_recv_val = 1'b0;
    mult_send_rdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_rdy     = w_grant_oh & {NREQ{reset}};
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mult_recv_val = 1'b1;
        if (mult_recv_rdy) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        mult_send_rdy = 1'b1;
        if (mult_send_val) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_val[r_owner] = 1'b1;
        if (resp_rdy[r_owner]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_op    <= w_sel_msg;
        r_owner <= w_grant;
      end
      if (r_state == S_WAIT && mult_send_val) begin
        r_res <= mult_send_msg;
      end
      if (r_state == S_RESP && resp_rdy[r_owner]) begin
        r_ptr <= (r_owner == OW'(NREQ-1)) ? '0 : r_owner + OW'(1);
        r_ops <= r_ops + 16'd1;
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign owner         = r_owner;
  assign ops_done      = r_ops;
  assign mult_recv_msg = r_op;
  assign resp_msg      = r_res;

endmodule
`default_nettype wire

// File: tb/tb_fpmult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmult_rr_arbiter
// Purpose  : Scoreboard bench for fpmult_rr_arbiter with a behavioural multiplier.
// Revision : 1.0
// ============================================================================
module tb_fpmult_rr_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 32;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*2*N-1:0] req_msg;
  logic [NREQ-1:0]   resp_val;
  logic [NREQ-1:0]   resp_rdy;
  logic [N-1:0]      resp_msg;
  logic              mult_recv_val;
  logic              mult_recv_rdy;
  logic [2*N-1:0]    mult_recv_msg;
  logic              mult_send_val;
  logic              mult_send_rdy;
  logic [N-1:0]      mult_send_msg;
  logic              busy;
  logic [1:0]        owner;
  logic [15:0]       ops_done;

  fpmult_rr_arbiter #(.NREQ(NREQ), .n(N)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mult_recv_val(mult_recv_val), .mult_recv_rdy(mult_recv_rdy), .mult_recv_msg(mult_recv_msg),
    .mult_send_val(mult_send_val), .mult_send_rdy(mult_send_rdy), .mult_send_msg(mult_send_msg),
    .busy(busy), .owner(owner), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] val;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Behavioural Q16.16 multiplier, fixed 3-cycle latency after accept.
  function automatic logic [31:0] fxmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[47:16];
  endfunction

  logic mult_busy;
  logic hold_recv;
  int   mult_cnt;
  assign mult_recv_rdy = !mult_busy && !hold_recv;
  assign mult_send_val = mult_busy && (mult_cnt == 0);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_busy     <= 1'b0;
      mult_cnt      <= 0;
      mult_send_msg <= '0;
    end else if (!mult_busy && mult_recv_val && mult_recv_rdy) begin
      mult_busy     <= 1'b1;
      mult_cnt      <= 3;
      mult_send_msg <= fxmul(mult_recv_msg[63:32], mult_recv_msg[31:0]);
    end else if (mult_busy && mult_cnt != 0) begin
      mult_cnt <= mult_cnt - 1;
    end else if (mult_send_val && mult_send_rdy) begin
      mult_busy <= 1'b0;
    end
  end

  // Monitor: a response handshake completes on the next posedge.
  always @(negedge clk) begin
    if (reset && (resp_val & resp_rdy) != '0) begin
      if (expq.size() == 0) begin
        check("unexpected_resp", {60'd0, resp_val}, 64'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("resp_val", {60'd0, resp_val}, 64'd1 << e.idx);
        check("resp_msg", {32'd0, resp_msg}, {32'd0, e.val});
        check("owner", {62'd0, owner}, {60'd0, e.idx});
      end
    end
  end

  task automatic wait_accept(input int g, input bit push, input logic [31:0] prod);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (req_rdy == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("grant%0d", g), {60'd0, req_rdy}, 64'd1 << g);
    if (push) expq.push_back('{idx: 4'(g), val: prod});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (expq.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("drain", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_msg[i*64 +: 64] = {a, b};
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    req_val   = '0;
    req_msg   = '0;
    resp_rdy  = '1;
    hold_recv = 1'b0;
    set_op(0, 32'h0001_0000, 32'h0002_0000);  // 1.0*2.0 = 2.0
    set_op(1, 32'h0003_0000, 32'h0002_0000);  // 3.0*2.0 = 6.0
    set_op(2, 32'h0002_8000, 32'h0002_0000);  // 2.5*2.0 = 5.0
    set_op(3, 32'h0001_8000, 32'h0003_0000);  // 1.5*3.0 = 4.5
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_owner", {62'd0, owner}, 64'd0);
    check("rst_ops", {48'd0, ops_done}, 64'd0);
    check("rst_recv_val", {63'd0, mult_recv_val}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single request from requester 1
    req_val = 4'b0010;
    wait_accept(1, 1'b1, 32'h0006_0000);
    req_val = '0;
    drain();
    check("ops_after_t1", {48'd0, ops_done}, 64'd1);

    // Move ptr to 0, then all four held
    req_val = 4'b1000;
    wait_accept(3, 1'b1, 32'h0004_8000);
    req_val = 4'b1111;
    wait_accept(0, 1'b1, 32'h0002_0000);
    wait_accept(1, 1'b1, 32'h0006_0000);
    wait_accept(2, 1'b1, 32'h0005_0000);
    wait_accept(3, 1'b1, 32'h0004_8000);
    wait_accept(0, 1'b1, 32'h0002_0000);
    req_val = '0;
    drain();

    // Serve 2 alone, then 3 must win over 0
    req_val = 4'b0100;
    wait_accept(2, 1'b1, 32'h0005_0000);
    req_val = 4'b1001;
    wait_accept(3, 1'b1, 32'h0004_8000);
    req_val = 4'b0001;
    wait_accept(0, 1'b1, 32'h0002_0000);
    req_val = '0;
    drain();

    // Response back-pressure with other resp_rdy bits high
    resp_rdy = '0;
    req_val  = 4'b0001;
    wait_accept(0, 1'b1, 32'h0002_0000);
    req_val = '0;
    cyc = 0;
    while (resp_val == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_resp_seen", {60'd0, resp_val}, 64'd1);
    @(posedge clk);
    #1;
    resp_rdy = 4'b1110;
    req_val  = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_val", {60'd0, resp_val}, 64'd1);
      check("t4_hold_msg", {32'd0, resp_msg}, 64'h0002_0000);
      check("t4_no_rdy", {60'd0, req_rdy}, 64'd0);
    end
    @(posedge clk);
    #1 resp_rdy = '1;
    wait_accept(2, 1'b1, 32'h0005_0000);
    req_val = '0;
    drain();

    // Multiplier operand back-pressure, negative operand
    hold_recv = 1'b1;
    set_op(1, 32'hFFFE_8000, 32'h0002_0000);
    req_val = 4'b0010;
    wait_accept(1, 1'b1, 32'hFFFD_0000);
    req_val = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_recv_val", {63'd0, mult_recv_val}, 64'd1);
      check("t5_recv_msg", mult_recv_msg, 64'hFFFE_8000_0002_0000);
    end
    @(posedge clk);
    #1 hold_recv = 1'b0;
    drain();

    // Asynchronous reset while waiting on the multiplier
    req_val = 4'b1000;
    wait_accept(3, 1'b0, 32'h0);
    req_val = '0;
    cyc = 0;
    while (!mult_send_rdy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_in_wait", {63'd0, mult_send_rdy}, 64'd1);
    #3;
    reset   = 1'b0;
    req_val = 4'b1001;
    #1;
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_req_rdy", {60'd0, req_rdy}, 64'd0);
    check("t6_resp_val", {60'd0, resp_val}, 64'd0);
    check("t6_mult", {62'd0, mult_recv_val, mult_send_rdy}, 64'd0);
    check("t6_ops", {48'd0, ops_done}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_accept(0, 1'b1, 32'h0002_0000);
    req_val = '0;
    drain();
    check("t6_ops_after", {48'd0, ops_done}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
